// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake between a sender and uart_tx
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 16x-oversampled UART transmitter, LSB first, optional parity
// Bit periods are counted in baud_tick pulses only, so tick gaps just stretch bits.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic      clk,
  input  logic      clr,
  input  logic      baud_tick,
  uart_tx_if.slave  tx,
  output logic      txd,
  output logic      busy,
  output logic      tx_done
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state, state_next;
  logic [3:0]           tick_cnt, tick_cnt_next;
  logic [IDX_W-1:0]     bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_bit, parity_next;
  logic                 txd_q, txd_next;
  logic                 done_q, done_next;
  logic                 bit_end;

  assign bit_end     = baud_tick && (tick_cnt == 4'hF);
  assign tx.tx_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign txd         = txd_q;
  assign tx_done     = done_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_cnt_next;
      bit_idx    <= bit_idx_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      txd_q      <= txd_next;
      done_q     <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift_reg;
    parity_next   = parity_bit;
    done_next     = 1'b0;

    if (state == IDLE) begin
      // The acceptance-cycle tick is deliberately not counted toward the start bit.
      if (tx.tx_valid) begin
        state_next    = START;
        tick_cnt_next = '0;
        bit_idx_next  = '0;
        shift_next    = tx.tx_data;
        parity_next   = (^tx.tx_data) ^ PARITY_ODD;
      end
    end else if (baud_tick) begin
      tick_cnt_next = tick_cnt + 4'd1;
    end

    case (state)
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
          if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
            bit_idx_next = '0;
            state_next   = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: ;
    endcase

    // txd is registered from the next state so the line changes exactly at bit edges.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      PARITY:  txd_next = parity_next;
      default: txd_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
// Three instances: no parity, even parity, odd parity; sel picks the one under test.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       baud_tick = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  int         sel = 0;
  int         tick_div = 1;
  bit         tick_rand = 1'b0;
  int         tick_ph = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  logic txd0, txd1, txd2, busy0, busy1, busy2, done0, done1, done2;
  logic txd_s, busy_s, done_s, ready_s;

  logic obs_txd[$], obs_busy[$], obs_done[$], obs_ready[$];
  int   obs_ticks[$];

  always #5 clk = ~clk;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();

  assign if0.tx_data  = tx_data;
  assign if1.tx_data  = tx_data;
  assign if2.tx_data  = tx_data;
  assign if0.tx_valid = tx_valid && (sel == 0);
  assign if1.tx_valid = tx_valid && (sel == 1);
  assign if2.tx_valid = tx_valid && (sel == 2);

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u0 (
    .clk(clk), .clr(clr), .baud_tick(baud_tick), .tx(if0.slave),
    .txd(txd0), .busy(busy0), .tx_done(done0));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
    .clk(clk), .clr(clr), .baud_tick(baud_tick), .tx(if1.slave),
    .txd(txd1), .busy(busy1), .tx_done(done1));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u2 (
    .clk(clk), .clr(clr), .baud_tick(baud_tick), .tx(if2.slave),
    .txd(txd2), .busy(busy2), .tx_done(done2));

  always_comb begin
    txd_s = txd0; busy_s = busy0; done_s = done0; ready_s = if0.tx_ready;
    case (sel)
      1: begin txd_s = txd1; busy_s = busy1; done_s = done1; ready_s = if1.tx_ready; end
      2: begin txd_s = txd2; busy_s = busy2; done_s = done2; ready_s = if2.tx_ready; end
      default: ;
    endcase
  end

  // Tick source: every tick_div clocks, or random with ~2/3 density.
  always @(negedge clk) begin
    if (tick_rand) baud_tick = ($urandom_range(0, 2) != 0);
    else           baud_tick = (tick_ph == 0);
    tick_ph = (tick_ph + 1 >= tick_div) ? 0 : tick_ph + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference frame: start, data LSB first, optional parity, stop; bit 0 goes out first.
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input bit pen,
                                             input bit podd, output int nb);
    logic [11:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    if (pen) f[9] = (^d) ^ podd;
    nb = pen ? 11 : 10;
    return f;
  endfunction

  function automatic logic model_txd(input logic [11:0] f, input int nb, input int tk);
    return (tk / 16 < nb) ? f[tk/16] : 1'b1;
  endfunction

  // Waits for a ready cycle with a tick present, then presents one byte for one edge.
  task automatic send(input logic [7:0] d, input bit hold);
    int w;
    w = 0;
    @(negedge clk); #1;
    while (!(ready_s && baud_tick) && w < 60) begin
      @(negedge clk); #1;
      w++;
    end
    if (w >= 60) begin
      n_checks++; n_fail++;
      $display("FAIL send_wait: ready=%b tick=%b, required ready=1 within 60 clks", ready_s, baud_tick);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  // Records outputs after each edge following acceptance, with ticks counted since then.
  task automatic capture(input int n);
    int t;
    t = 0;
    obs_txd.delete(); obs_busy.delete(); obs_done.delete(); obs_ready.delete(); obs_ticks.delete();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (baud_tick) t++;
      end
      obs_txd.push_back(txd_s);
      obs_busy.push_back(busy_s);
      obs_done.push_back(done_s);
      obs_ready.push_back(ready_s);
      obs_ticks.push_back(t);
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({txd0, txd1, txd2} !== 3'b111) begin
      n_fail++; $display("FAIL reset_txd: got %b required 111", {txd0, txd1, txd2});
    end
    n_checks++;
    if ({busy0, busy1, busy2} !== 3'b000) begin
      n_fail++; $display("FAIL reset_busy: got %b required 000", {busy0, busy1, busy2});
    end
    n_checks++;
    if ({done0, done1, done2} !== 3'b000) begin
      n_fail++; $display("FAIL reset_done: got %b required 000", {done0, done1, done2});
    end
    n_checks++;
    if ({if0.tx_ready, if1.tx_ready, if2.tx_ready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b required 111", {if0.tx_ready, if1.tx_ready, if2.tx_ready});
    end
    // clr wins over an acceptance in the same cycle
    sel = 0; tx_data = 8'h5A; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy_s !== 1'b0 || ready_s !== 1'b1 || txd_s !== 1'b1) begin
      n_fail++; $display("FAIL reset_priority: busy=%b ready=%b txd=%b required 0 1 1", busy_s, ready_s, txd_s);
    end
  endtask

  task automatic test_a5;
    logic [9:0] exp_bits;
    exp_bits = 10'b1101001010;
    sel = 0; tick_rand = 1'b0; tick_div = 1;
    send(8'hA5, 1'b0);
    capture(175);
    for (int i = 0; i < 175; i++) begin
      logic et, eb, ed;
      et = (i < 160) ? exp_bits[i/16] : 1'b1;
      eb = (i < 160);
      ed = (i == 160);
      n_checks++;
      if (obs_txd[i] !== et || obs_busy[i] !== eb || obs_done[i] !== ed || obs_ready[i] !== !eb) begin
        n_fail++;
        $display("FAIL a5_frame clk %0d: txd=%b busy=%b done=%b ready=%b required %b %b %b %b",
                 i, obs_txd[i], obs_busy[i], obs_done[i], obs_ready[i], et, eb, ed, !eb);
      end
    end
  endtask

  task automatic test_parity;
    logic [11:0] f;
    int nb;
    tick_rand = 1'b0; tick_div = 1;
    for (int s = 1; s <= 2; s++) begin
      sel = s;
      f = frame_bits(8'h07, 1'b1, s == 2, nb);
      send(8'h07, 1'b0);
      capture(190);
      n_checks++;
      if (obs_txd[152] !== ((s == 1) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL parity_bit sel %0d: got %b required %b", s, obs_txd[152], (s == 1) ? 1'b1 : 1'b0);
      end
      n_checks++;
      if (obs_done[176] !== 1'b1 || obs_busy[175] !== 1'b1) begin
        n_fail++; $display("FAIL parity_len sel %0d: done@176=%b busy@175=%b required 1 1", s, obs_done[176], obs_busy[175]);
      end
      for (int i = 0; i < 190; i++) begin
        n_checks++;
        if (obs_txd[i] !== model_txd(f, nb, obs_ticks[i])) begin
          n_fail++; $display("FAIL parity_frame sel %0d clk %0d: txd=%b required %b", s, i, obs_txd[i], model_txd(f, nb, obs_ticks[i]));
        end
      end
    end
  endtask

  task automatic test_slow_ticks;
    int lows, first_done;
    sel = 0; tick_rand = 1'b0; tick_div = 3;
    send(8'h00, 1'b0);
    capture(495);
    lows = 0; first_done = -1;
    for (int i = 0; i < 495; i++) begin
      if (obs_txd[i] === 1'b0) lows++;
      if (obs_done[i] === 1'b1 && first_done < 0) first_done = i;
      n_checks++;
      if (obs_txd[i] !== ((i < 432) ? 1'b0 : 1'b1)) begin
        n_fail++; $display("FAIL slow_txd clk %0d: got %b required %b", i, obs_txd[i], (i < 432) ? 1'b0 : 1'b1);
      end
    end
    n_checks++;
    if (lows != 432) begin
      n_fail++; $display("FAIL slow_low_len: got %0d clks required 432", lows);
    end
    n_checks++;
    if (first_done != 480) begin
      n_fail++; $display("FAIL slow_done: got clk %0d required 480", first_done);
    end
    tick_div = 1;
  endtask

  task automatic test_back_to_back;
    logic [11:0] f1, f2;
    int nb;
    sel = 0; tick_rand = 1'b0; tick_div = 1;
    f1 = frame_bits(8'h55, 1'b0, 1'b0, nb);
    f2 = frame_bits(8'h3C, 1'b0, 1'b0, nb);
    send(8'h55, 1'b1);
    fork
      capture(340);
      begin
        repeat (40) @(posedge clk);
        #2 tx_data = 8'hAA;
        repeat (100) @(posedge clk);
        #2 tx_data = 8'h3C;
        repeat (22) @(posedge clk);
        #2 tx_valid = 1'b0;
      end
    join
    for (int i = 0; i < 340; i++) begin
      logic et, eb, ed;
      if (i < 160)                  et = f1[i/16];
      else if (i >= 161 && i < 321) et = f2[(i-161)/16];
      else                          et = 1'b1;
      eb = (i < 160) || (i >= 161 && i < 321);
      ed = (i == 160) || (i == 321);
      n_checks++;
      if (obs_txd[i] !== et || obs_busy[i] !== eb || obs_done[i] !== ed) begin
        n_fail++;
        $display("FAIL b2b clk %0d: txd=%b busy=%b done=%b required %b %b %b",
                 i, obs_txd[i], obs_busy[i], obs_done[i], et, eb, ed);
      end
    end
  endtask

  task automatic test_abort;
    logic [11:0] f;
    int nb;
    bit saw_done;
    sel = 0; tick_rand = 1'b0; tick_div = 1;
    send(8'hFF, 1'b0);
    repeat (84) @(posedge clk);
    #1;
    n_checks++;
    if (busy_s !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre_busy: got %b required 1", busy_s);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n_checks++;
    if (txd_s !== 1'b1 || busy_s !== 1'b0 || ready_s !== 1'b1 || done_s !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: txd=%b busy=%b ready=%b done=%b required 1 0 1 0", txd_s, busy_s, ready_s, done_s);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done_s === 1'b1 || busy_s !== 1'b0) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++; $display("FAIL abort_quiet: activity=%b required 0", saw_done);
    end
    f = frame_bits(8'h81, 1'b0, 1'b0, nb);
    send(8'h81, 1'b0);
    capture(170);
    for (int i = 0; i < 170; i++) begin
      n_checks++;
      if (obs_txd[i] !== model_txd(f, nb, obs_ticks[i]) || obs_done[i] !== (i == 160)) begin
        n_fail++; $display("FAIL abort_resend clk %0d: txd=%b done=%b required %b %b",
                           i, obs_txd[i], obs_done[i], model_txd(f, nb, obs_ticks[i]), i == 160);
      end
    end
  endtask

  task automatic test_random;
    logic [11:0] f;
    logic [7:0] d;
    int nb, lim;
    tick_rand = 1'b1;
    for (int n = 0; n < 6; n++) begin
      sel = $urandom_range(0, 2);
      d   = 8'($urandom);
      f   = frame_bits(d, sel != 0, sel == 2, nb);
      lim = 16 * nb;
      send(d, 1'b0);
      capture(500);
      for (int i = 0; i < 500; i++) begin
        logic et, eb, ed;
        et = model_txd(f, nb, obs_ticks[i]);
        eb = obs_ticks[i] < lim;
        ed = !eb && i > 0 && obs_ticks[i-1] < lim;
        n_checks++;
        if (obs_txd[i] !== et || obs_busy[i] !== eb || obs_done[i] !== ed || obs_ready[i] !== !eb) begin
          n_fail++;
          $display("FAIL random sel %0d data %h clk %0d: txd=%b busy=%b done=%b ready=%b required %b %b %b %b",
                   sel, d, i, obs_txd[i], obs_busy[i], obs_done[i], obs_ready[i], et, eb, ed, !eb);
        end
      end
    end
    tick_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a5();
    test_parity();
    test_slow_ticks();
    test_back_to_back();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL take parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 SHALL take parameter PARITY_EN, default 0, 1 inserts a parity bit after the data bits.
REQ-003 SHALL take parameter PARITY_ODD, default 0, 0 selects even parity and 1 selects odd parity (ignored when PARITY_EN=0).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-005 SHALL have port clr  input  1  synchronous active-high reset.
REQ-006 SHALL have port baud_tick  input  1  one-clk-wide pulse at 16x the baud rate (upstream counter-chain carry).
REQ-007 SHALL have port tx_data  input  DATA_BITS  byte to send.
REQ-008 SHALL have port tx_valid  input  1  sender requests transmission of tx_data.
REQ-009 SHALL have port tx_ready  output  1  block can accept a byte this cycle.
REQ-010 SHALL have port txd  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port tx_done  output  1  one-clk pulse at frame completion.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL accept a byte only on a rising edge where tx_valid=1 and tx_ready=1.
REQ-015 SHALL latch tx_data into a shift register on acceptance; later tx_data changes SHALL NOT affect the frame.
REQ-016 SHALL compute parity on acceptance: XOR of the data bits, inverted when PARITY_ODD=1.
REQ-017 SHALL assert tx_ready=1 only in IDLE, combinationally from state.
REQ-018 SHALL move IDLE->START on acceptance, clear the 4-bit tick counter and bit index, and drive txd=0 from the following cycle.
REQ-019 SHALL increment the tick counter only on cycles with baud_tick=1, wrapping 15->0.
REQ-020 SHALL end a bit period on a cycle with baud_tick=1 and tick counter=15, so each bit lasts exactly 16 baud_ticks.
REQ-021 SHALL go START->DATA at end of bit period.
REQ-022 SHALL, in DATA, drive txd from shift register bit 0 (LSB first) and shift right at each bit end.
REQ-023 SHALL leave DATA after DATA_BITS bit periods, going to PARITY if PARITY_EN=1, else to STOP.
REQ-024 SHALL, in PARITY, drive txd = parity bit for one bit period, then go to STOP.
REQ-025 SHALL, in STOP, drive txd=1 for one bit period, then go to IDLE and pulse tx_done=1 for exactly that transition cycle.
REQ-026 SHALL assert busy=1 in every state except IDLE.
REQ-027 SHALL drive txd=1 in IDLE.
REQ-028 SHALL register txd so that it is glitch-free.
REQ-029 SHALL ignore tx_valid while busy=1; no queueing, no data corruption.
REQ-030 SHALL allow back-to-back frames: acceptance is possible on the first cycle after tx_done, giving no extra idle bit.
REQ-031 SHALL hold state and txd when baud_tick=0; tick gaps only stretch bit periods.
REQ-032 SHALL not start a bit period on acceptance even if baud_tick=1 on the acceptance cycle; that tick is not counted.

Reset
REQ-033 SHALL, when clr=1 at a rising edge, force state=IDLE, tick counter=0, bit index=0, shift register=0, txd=1, busy=0, tx_done=0, tx_ready=1 (tx_ready following state).
REQ-034 SHALL let clr take priority over acceptance and ticks in the same cycle.
REQ-035 SHALL, when clr is asserted mid-frame, abort the frame, return txd high on the next edge, and not pulse tx_done.

Verification
REQ-036 SHALL verify: baud_tick=1 every clk, PARITY_EN=0, send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1 each held 16 clks; tx_done 160 clks after acceptance edge; tx_ready high the next cycle.
REQ-037 SHALL verify: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame length 176 clks.
REQ-038 SHALL verify: baud_tick every 3rd clk, send 0x00 -> each bit lasts 48 clks and txd low for 432 clks (start plus 8 data bits).
REQ-039 SHALL verify: tx_valid held high with 0x55 then 0x3C -> second frame's start bit immediately follows the first stop bit, and tx_data changes during the first frame are ignored.
REQ-040 SHALL verify: clr pulsed during DATA bit 4 of 0xFF -> next cycle txd=1, busy=0, tx_ready=1, no tx_done; a subsequent send of 0x81 is correct.
